adbg_cpu_seq: RTL and testbench



---
 rtl/adbg_cpu_seq_pkg.sv | 26 ++
 rtl/adbg_cpu_seq_if.sv | 38 +++
 rtl/adbg_ff1.sv | 23 ++
 rtl/adbg_cpu_seq.sv | 138 +++++++++++++
 tb/tb_adbg_cpu_seq.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/adbg_cpu_seq_pkg.sv
// Shared types for the CPU debug-bus sequencer: FSM states, response beat
// layout and the core index width helper.
package adbg_cpu_seq_pkg;

  // Core index field width inside the response struct; covers up to 32 cores.
  localparam int unsigned CORE_IDX_W = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef struct packed {
    logic [CORE_IDX_W-1:0] core;
    logic [31:0]           data;
    logic                  err;
    logic                  last;
  } rsp_t;

  // Index width for a vector of n entries, never below 1 bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adbg_cpu_seq_if.sv
// Request/response handshake bundle between the JTAG-side CPU command logic
// (master) and the sequencer (slave).
//
// Handshake rule for both channels: a transfer happens on the rising clock
// edge where valid and ready are both high. Once valid is raised, the payload
// is held stable and valid stays high until that edge; ready may change freely.
interface adbg_cpu_seq_if #(
  parameter int unsigned NB_CORES = 4
);
  import adbg_cpu_seq_pkg::*;

  localparam int unsigned CW = idx_w(NB_CORES);

  logic                req_valid_i;
  logic                req_ready_o;
  logic                req_we_i;
  logic [31:0]         req_addr_i;
  logic [31:0]         req_data_i;
  logic [NB_CORES-1:0] req_mask_i;

  logic                rsp_valid_o;
  logic                rsp_ready_i;
  logic [CW-1:0]       rsp_core_o;
  logic [31:0]         rsp_data_o;
  logic                rsp_err_o;
  logic                rsp_last_o;

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_data_i, req_mask_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_core_o, rsp_data_o, rsp_err_o, rsp_last_o
  );

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_data_i, req_mask_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_core_o, rsp_data_o, rsp_err_o, rsp_last_o
  );

endinterface

// File: rtl/adbg_ff1.sv
// Find-first-one: index of the lowest set bit of vec, plus an empty flag.
module adbg_ff1 #(
  parameter int unsigned W  = 4,
  parameter int unsigned IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          empty
);

  // Scan from the top down so the lowest set bit is the last one to win.
  always_comb begin
    idx   = '0;
    empty = 1'b1;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = IW'(i);
        empty = 1'b0;
      end
    end
  end

endmodule

// File: rtl/adbg_cpu_seq.sv
// Runs one debug register access on every core selected by the request mask,
// lowest index first, returning one response beat per core. Each access is
// bounded by TIMEOUT strobe cycles.
module adbg_cpu_seq
  import adbg_cpu_seq_pkg::*;
#(
  parameter int unsigned NB_CORES = 4,
  parameter int unsigned TIMEOUT  = 256
) (
  input  logic                     cpu_clk_i,
  input  logic                     rst_i,
  adbg_cpu_seq_if.slave            bus,
  output logic [NB_CORES-1:0][31:0] cpu_addr_o,
  output logic [NB_CORES-1:0][31:0] cpu_data_o,
  output logic [NB_CORES-1:0]      cpu_stb_o,
  output logic [NB_CORES-1:0]      cpu_we_o,
  input  logic [NB_CORES-1:0][31:0] cpu_data_i,
  input  logic [NB_CORES-1:0]      cpu_ack_i,
  output state_t                   state_o
);

  localparam int unsigned CW    = idx_w(NB_CORES);
  localparam int unsigned CNT_W = idx_w(TIMEOUT);

  state_t              state_q, state_d;
  logic [NB_CORES-1:0] pend_q;
  logic                we_q;
  logic [31:0]         addr_q;
  logic [31:0]         data_q;
  logic [CNT_W-1:0]    cnt_q;
  rsp_t                rsp_q;

  logic [CW-1:0]       cur;
  logic                pend_empty;
  logic [NB_CORES-1:0] cur_bit;
  logic                cur_ack;
  logic                timeout;

  adbg_ff1 #(.W(NB_CORES), .IW(CW)) u_ff1 (
    .vec   (pend_q),
    .idx   (cur),
    .empty (pend_empty)
  );

  // One-hot of the current core, its ack, and the last-cycle-of-access flag.
  always_comb begin
    cur_bit      = '0;
    cur_bit[cur] = 1'b1;
    cur_ack      = cpu_ack_i[cur];
    timeout      = (cnt_q == CNT_W'(TIMEOUT - 1));
  end

  // State register.
  always_ff @(posedge cpu_clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode; an ack on the timeout cycle leaves the same way as a
  // timeout, the difference is only in the captured error flag.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req_valid_i) state_d = (bus.req_mask_i != '0) ? ACCESS : RESP;
      ACCESS:  if (cur_ack || timeout) state_d = RESP;
      RESP:    if (bus.rsp_ready_i) state_d = pend_empty ? IDLE : ACCESS;
      default: state_d = IDLE;
    endcase
  end

  // Request latches, pending mask, access timer and captured response beat.
  always_ff @(posedge cpu_clk_i) begin
    if (rst_i) begin
      pend_q <= '0;
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      cnt_q  <= '0;
      rsp_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (bus.req_valid_i) begin
            we_q   <= bus.req_we_i;
            addr_q <= bus.req_addr_i;
            data_q <= bus.req_data_i;
            pend_q <= bus.req_mask_i;
            // Only reaches the response port when the mask is empty.
            rsp_q  <= '{core: '0, data: '0, err: 1'b1, last: 1'b1};
          end
        end
        ACCESS: begin
          if (cur_ack || timeout) begin
            cnt_q      <= '0;
            pend_q     <= pend_q & ~cur_bit;
            rsp_q.core <= CORE_IDX_W'(cur);
            rsp_q.data <= (cur_ack && !we_q) ? cpu_data_i[cur] : 32'd0;
            rsp_q.err  <= !cur_ack;
            rsp_q.last <= ((pend_q & ~cur_bit) == '0);
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: cnt_q <= '0;
      endcase
    end
  end

  // Outputs decode registered state only: strobe the current core in ACCESS,
  // present the captured beat in RESP, everything else stays at zero.
  always_comb begin
    cpu_stb_o       = '0;
    cpu_we_o        = '0;
    cpu_addr_o      = '0;
    cpu_data_o      = '0;
    bus.req_ready_o = (state_q == IDLE);
    bus.rsp_valid_o = (state_q == RESP);
    bus.rsp_core_o  = '0;
    bus.rsp_data_o  = '0;
    bus.rsp_err_o   = 1'b0;
    bus.rsp_last_o  = 1'b0;
    state_o         = state_q;
    if (state_q == ACCESS) begin
      cpu_stb_o[cur]  = 1'b1;
      cpu_we_o[cur]   = we_q;
      cpu_addr_o[cur] = addr_q;
      cpu_data_o[cur] = data_q;
    end
    if (state_q == RESP) begin
      bus.rsp_core_o = CW'(rsp_q.core);
      bus.rsp_data_o = rsp_q.data;
      bus.rsp_err_o  = rsp_q.err;
      bus.rsp_last_o = rsp_q.last;
    end
  end

endmodule

// File: tb/tb_adbg_cpu_seq.sv
// Bench for adbg_cpu_seq: directed cases plus randomized requests, checked
// against a per-request list of expected core accesses and response beats.
module tb_adbg_cpu_seq;
  import adbg_cpu_seq_pkg::*;

  localparam int NB = 4;
  localparam int T  = 256;
  localparam int CW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adbg_cpu_seq_if #(.NB_CORES(NB)) bus ();

  logic [NB-1:0][31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [NB-1:0]       cpu_stb, cpu_we, cpu_ack;
  state_t              dbg_state;

  adbg_cpu_seq #(.NB_CORES(NB), .TIMEOUT(T)) dut (
    .cpu_clk_i  (clk),
    .rst_i      (rst),
    .bus        (bus),
    .cpu_addr_o (cpu_addr),
    .cpu_data_o (cpu_wdata),
    .cpu_stb_o  (cpu_stb),
    .cpu_we_o   (cpu_we),
    .cpu_data_i (cpu_rdata),
    .cpu_ack_i  (cpu_ack),
    .state_o    (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Expected beats {core, data, err, last} and accesses {core, strobe cycles}.
  logic [35:0] exp_q[$];
  logic [17:0] acc_q[$];

  // Per-core ack latency: ack is raised in the lat-th strobe cycle.
  int          lat[NB];
  logic        cur_we;
  logic [31:0] cur_addr, cur_wdata;
  int          rdy_mode;   // 0 random ready, 1 hold first 10 cycles of each beat
  logic        force_ack;  // ack every core that is not being strobed

  // Reference: each selected core, ascending, gets an access lasting its ack
  // latency (capped at T) and a beat; a missing ack within T cycles is an error.
  task automatic model_req(input logic we, input logic [NB-1:0] mask);
    int last_i;
    last_i = -1;
    for (int i = 0; i < NB; i++) if (mask[i]) last_i = i;
    if (mask == '0) exp_q.push_back({CW'(0), 32'd0, 1'b1, 1'b1});
    for (int i = 0; i < NB; i++) begin
      if (mask[i]) begin
        logic ok;
        int   len;
        ok  = (lat[i] <= T);
        len = ok ? lat[i] : T;
        acc_q.push_back({CW'(i), 16'(len)});
        exp_q.push_back({CW'(i), (ok && !we) ? cpu_rdata[i] : 32'd0, !ok, (i == last_i)});
      end
    end
  endtask

  // ---------------- core responders and monitor ----------------
  int          scnt[NB];
  logic [NB-1:0] prev_stb = '0;
  logic        ack_prev = 1'b0;
  logic        prev_hold = 1'b0;
  logic [35:0] prev_beat = '0;
  int          hold_cnt = 0;

  always @(negedge clk) begin
    logic [35:0] cur_beat;
    logic [NB-1:0][31:0] e_addr, e_data;
    logic [NB-1:0] e_we;
    // response ready
    if (rdy_mode == 1) begin
      if (bus.rsp_valid_o && hold_cnt < 10) begin
        bus.rsp_ready_i = 1'b0;
        hold_cnt++;
      end else begin
        bus.rsp_ready_i = 1'b1;
        if (!bus.rsp_valid_o) hold_cnt = 0;
      end
    end else begin
      hold_cnt = 0;
      bus.rsp_ready_i = ($urandom_range(0, 2) != 0);
    end
    cur_beat = {bus.rsp_core_o, bus.rsp_data_o, bus.rsp_err_o, bus.rsp_last_o};
    if (!rst) begin
      if (prev_hold) check("rsp_stable", {bus.rsp_valid_o, cur_beat}, {1'b1, prev_beat});
      if (ack_prev) check("ack_to_resp", {bus.rsp_valid_o, cpu_stb}, {1'b1, NB'(0)});
      if (bus.rsp_valid_o) check("no_stb_in_resp", cpu_stb, '0);
      if (bus.rsp_valid_o && bus.rsp_ready_i) begin
        if (exp_q.size() == 0) check("unexp_beat", 1, 0);
        else check("beat", cur_beat, exp_q.pop_front());
      end
    end
    prev_hold = bus.rsp_valid_o && !bus.rsp_ready_i;
    prev_beat = cur_beat;
    if (cpu_stb != '0) check("stb_onehot", $countones(cpu_stb), 1);
    ack_prev = 1'b0;
    for (int c = 0; c < NB; c++) begin
      if (prev_stb[c] && !cpu_stb[c]) begin
        if (!rst) begin
          if (acc_q.size() == 0) check("unexp_acc", 1, 0);
          else check("acc_core_len", {CW'(c), 16'(scnt[c])}, acc_q.pop_front());
        end
        scnt[c] = 0;
      end
      if (cpu_stb[c]) begin
        scnt[c]++;
        if (scnt[c] == 1) begin
          e_we = '0; e_addr = '0; e_data = '0;
          e_we[c] = cur_we; e_addr[c] = cur_addr; e_data[c] = cur_wdata;
          check("bus_we", cpu_we, e_we);
          check("bus_addr", cpu_addr, e_addr);
          check("bus_wdata", cpu_wdata, e_data);
        end
        cpu_ack[c] = (scnt[c] == lat[c]);
        if (cpu_ack[c]) ack_prev = 1'b1;
      end else begin
        cpu_ack[c] = force_ack || ($urandom_range(0, 2) == 0);
      end
    end
    prev_stb = cpu_stb;
  end

  // ---------------- driver tasks ----------------
  task automatic send_req(input logic we, input logic [31:0] addr, input logic [31:0] data,
                          input logic [NB-1:0] mask);
    int n;
    logic [NB-1:0] first;
    cur_we = we; cur_addr = addr; cur_wdata = data;
    model_req(we, mask);
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = we;
    bus.req_addr_i  = addr;
    bus.req_data_i  = data;
    bus.req_mask_i  = mask;
    n = 0;
    while (!bus.req_ready_o && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("req_accept_in_time", (n < 2000), 1);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    bus.req_mask_i  = NB'($urandom());
    first = mask & (~mask + NB'(1));
    if (mask != '0) check("first_stb", cpu_stb, first);
    else check("empty_mask_resp", {bus.rsp_valid_o, cpu_stb}, {1'b1, NB'(0)});
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || acc_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", {exp_q.size(), acc_q.size()}, 0);
  endtask

  task automatic randomize_rdata();
    for (int i = 0; i < NB; i++) cpu_rdata[i] = $urandom();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    bus.req_valid_i = 1'b0;
    bus.req_we_i    = 1'b0;
    bus.req_addr_i  = '0;
    bus.req_data_i  = '0;
    bus.req_mask_i  = '0;
    bus.rsp_ready_i = 1'b0;
    cpu_ack   = '0;
    force_ack = 1'b0;
    rdy_mode  = 0;
    cur_we = 1'b0; cur_addr = '0; cur_wdata = '0;
    for (int i = 0; i < NB; i++) begin lat[i] = 1; scnt[i] = 0; end
    randomize_rdata();
    repeat (3) @(negedge clk);
    check("rst_ready", bus.req_ready_o, 1);
    check("rst_outputs", {bus.rsp_valid_o, cpu_stb, cpu_we, bus.rsp_data_o}, 0);
    check("rst_state", dbg_state, IDLE);
    rst = 1'b0;
    @(negedge clk);

    // single read, core 2 acks in its 3rd strobe cycle
    lat[2] = 3; cpu_rdata[2] = 32'hDEADBEEF;
    send_req(1'b0, 32'h0000_0100, 32'h0, 4'b0100);
    wait_done();

    // broadcast write, one-cycle acks
    for (int i = 0; i < NB; i++) lat[i] = 1;
    send_req(1'b1, 32'h0000_2000, 32'h0000_1234, 4'b1011);
    wait_done();

    // empty mask
    send_req(1'b0, 32'h10, 32'h0, 4'b0000);
    wait_done();

    // timeout on core 1, then an ack on the very last strobe cycle
    lat[1] = T + 1;
    send_req(1'b0, 32'h44, 32'h0, 4'b0010);
    wait_done();
    lat[1] = T; randomize_rdata();
    send_req(1'b0, 32'h44, 32'h0, 4'b0010);
    wait_done();

    // backpressure with acks hammering idle cores
    rdy_mode = 1; force_ack = 1'b1;
    lat[1] = 2; lat[2] = 4; randomize_rdata();
    send_req(1'b0, 32'h88, 32'h0, 4'b0110);
    wait_done();
    rdy_mode = 0; force_ack = 1'b0;

    // reset in the middle of an access
    lat[0] = 50;
    send_req(1'b0, 32'hC0, 32'h0, 4'b0001);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    check("midrst_outputs", {bus.rsp_valid_o, cpu_stb, cpu_we, cpu_addr}, 0);
    check("midrst_ready", bus.req_ready_o, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_quiet", {bus.rsp_valid_o, cpu_stb}, 0);
    lat[0] = 2; randomize_rdata();
    send_req(1'b0, 32'hC4, 32'h0, 4'b0001);
    wait_done();

    // randomized requests
    for (int r = 0; r < 40; r++) begin
      logic we;
      logic [NB-1:0] mask;
      we   = 1'($urandom_range(0, 1));
      mask = ($urandom_range(0, 9) == 0) ? '0 : NB'($urandom());
      for (int i = 0; i < NB; i++)
        lat[i] = ($urandom_range(0, 29) == 0) ? T + 1 : $urandom_range(1, 6);
      randomize_rdata();
      send_req(we, $urandom(), $urandom(), mask);
      wait_done();
    end

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
